// File: rtl/count_sequencer_if.sv
// Control/status bundle between the requesting logic and count_sequencer.
// The master side issues start/target/step2/pause/abort; the slave side returns count/busy/done/err.
interface count_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             step2;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, target, step2, pause, abort,
    input  count, busy, done, err
  );

  modport slave (
    input  start, target, step2, pause, abort,
    output count, busy, done, err
  );
endinterface

// File: rtl/count_sequencer.sv
// Sequencer FSM that counts 0..target in steps of 1 or 2, with pause and abort.
// Define COUNT_SEQ_TIMEOUT_EN to add a hold timeout that pulses err after HOLD_LIMIT HOLD cycles.
module count_sequencer #(
  parameter int WIDTH      = 4,
  parameter int HOLD_LIMIT = 8
) (
  input  logic             clk,
  input  logic             nReset,
  count_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [WIDTH:0] STEP_ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP_TWO = (WIDTH+1)'(2);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] target_reg, target_next;
  logic             step2_reg, step2_next;
  logic             busy_reg, done_reg, err_reg, err_next;
  logic [WIDTH:0]   sum;
  logic             timeout;

  // One extra bit so a step past the top of the range saturates instead of wrapping.
  assign sum = {1'b0, count_reg} + (step2_reg ? STEP_TWO : STEP_ONE);

`ifdef COUNT_SEQ_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_LIMIT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LIMIT - 1);

  logic [HW-1:0] hold_cnt_reg;

  // Counts HOLD cycles already spent; the HOLD_LIMIT-th cycle is the one that times out.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hold_cnt_reg <= '0;
    end else if (state_reg == HOLD && state_next == HOLD) begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end else begin
      hold_cnt_reg <= '0;
    end
  end

  assign timeout = (hold_cnt_reg == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    target_next = target_reg;
    step2_next  = step2_reg;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          target_next = bus.target;
          step2_next  = bus.step2;
          count_next  = '0;
          state_next  = (bus.target == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (bus.pause) begin
          state_next = HOLD;
        end else if (sum >= {1'b0, target_reg}) begin
          count_next = target_reg;
          state_next = DONE;
        end else begin
          count_next = sum[WIDTH-1:0];
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (!bus.pause) begin
          state_next = RUN;
        end else if (timeout) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      target_reg <= '0;
      step2_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      target_reg <= target_next;
      step2_reg  <= step2_next;
      busy_reg   <= (state_next == RUN) || (state_next == HOLD);
      done_reg   <= (state_next == DONE);
      err_reg    <= err_next;
    end
  end

  assign bus.count = count_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.err   = err_reg;
endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed runs with literal expectations plus randomized traffic
// checked every cycle against a behavioural model (honours COUNT_SEQ_TIMEOUT_EN).
module tb_count_sequencer;
  localparam int WIDTH      = 4;
  localparam int HOLD_LIMIT = 8;

  logic clk;
  logic nReset;
  int   checks;
  int   failures;
  bit   check_en;

  count_sequencer_if #(.WIDTH(WIDTH)) bus ();

  count_sequencer #(.WIDTH(WIDTH), .HOLD_LIMIT(HOLD_LIMIT)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases: 0 idle, 1 counting, 2 paused, 3 finished.
  int m_phase;
  int m_count;
  int m_target;
  int m_step;
  int m_hold;
  bit m_err;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_phase = 0; m_count = 0; m_target = 0; m_step = 1; m_hold = 0; m_err = 0;
    end else begin
      m_err = 0;
      case (m_phase)
        0: if (bus.start) begin
          m_target = int'(bus.target);
          m_step   = bus.step2 ? 2 : 1;
          m_count  = 0;
          m_phase  = (m_target == 0) ? 3 : 1;
        end
        1: begin
          if (bus.abort) m_phase = 0;
          else if (bus.pause) begin m_phase = 2; m_hold = 0; end
          else if (m_count + m_step >= m_target) begin m_count = m_target; m_phase = 3; end
          else m_count = m_count + m_step;
        end
        2: begin
          m_hold = m_hold + 1;
          if (bus.abort) m_phase = 0;
          else if (!bus.pause) m_phase = 1;
`ifdef COUNT_SEQ_TIMEOUT_EN
          else if (m_hold >= HOLD_LIMIT) begin m_phase = 0; m_err = 1; end
`endif
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_count", int'(bus.count), m_count);
      check("cyc_busy", int'(bus.busy), (m_phase == 1 || m_phase == 2) ? 1 : 0);
      check("cyc_done", int'(bus.done), (m_phase == 3) ? 1 : 0);
      check("cyc_err", int'(bus.err), int'(m_err));
    end
  end

  task automatic do_start(input int t, input bit s2);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = 4'(t);
    bus.step2  = s2;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Watches a run from the negedge after start, optionally injecting pause/abort/start spam.
  task automatic observe(input int pause_at, input int pause_len, input int abort_at,
                         input bit spam, input int window,
                         output int nb, output int nd, output int ne, output int fc,
                         output logic [63:0] code);
    int pl;
    bit p_done;
    bit a_done;
    pl = 0; p_done = 0; a_done = 0; nb = 0; nd = 0; ne = 0; code = '0;
    for (int i = 0; i < window; i++) begin
      if (bus.busy) begin nb++; code = {code[59:0], bus.count}; end
      if (bus.done) nd++;
      if (bus.err) ne++;
      if (pl > 0) begin
        pl--;
        if (pl == 0) bus.pause = 1'b0;
      end else if (!p_done && pause_at >= 0 && bus.busy && int'(bus.count) == pause_at) begin
        bus.pause = 1'b1; pl = pause_len; p_done = 1;
      end
      bus.abort = !a_done && abort_at >= 0 && bus.busy && int'(bus.count) == abort_at;
      if (bus.abort) a_done = 1;
      if (spam) begin bus.start = bus.busy; bus.target = 4'd2; bus.step2 = 1'b1; end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    fc = int'(bus.count);
  endtask

  task automatic run_case(input string name, input int t, input bit s2,
                          input int pause_at, input int pause_len, input int abort_at, input bit spam,
                          input int exp_nb, input int exp_nd, input int exp_ne, input int exp_fc,
                          input logic [63:0] exp_code);
    int nb, nd, ne, fc;
    logic [63:0] code;
    do_start(t, s2);
    observe(pause_at, pause_len, abort_at, spam, 40, nb, nd, ne, fc, code);
    check({name, "_busy_cycles"}, nb, exp_nb);
    check({name, "_done_pulses"}, nd, exp_nd);
    check({name, "_err_pulses"}, ne, exp_ne);
    check({name, "_final_count"}, fc, exp_fc);
    checks++;
    if (code !== exp_code) begin
      failures++;
      $display("FAIL %s_sequence actual=%h expected=%h", name, code, exp_code);
    end
    $display("run %s target=%0d step2=%0d busy=%0d done=%0d err=%0d count=%0d seq=%h",
             name, t, s2, nb, nd, ne, fc, code);
  endtask

  int burst;
  int waited;

  initial begin
    #200000;
    $display("FAIL watchdog expired time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; check_en = 0; burst = 0;
    nReset = 1'b0;
    bus.start = 0; bus.target = '0; bus.step2 = 0; bus.pause = 0; bus.abort = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_count", int'(bus.count), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_err", int'(bus.err), 0);
    nReset = 1'b1;
    check_en = 1;

    // Asynchronous reset in the middle of a run.
    do_start(8, 0);
    waited = 0;
    while (int'(bus.count) != 3 && waited < 20) begin @(negedge clk); waited++; end
    check("midrun_reached_3", int'(bus.count), 3);
    #2 nReset = 1'b0;
    #1;
    check("async_reset_count", int'(bus.count), 0);
    check("async_reset_busy", int'(bus.busy), 0);
    check("async_reset_done", int'(bus.done), 0);
    @(negedge clk);
    nReset = 1'b1;
    $display("run async_reset count=%0d busy=%0d done=%0d", bus.count, bus.busy, bus.done);

    run_case("t6_s1", 6, 0, -1, 0, -1, 0, 6, 1, 0, 6, 64'h012345);
    run_case("t7_s2", 7, 1, -1, 0, -1, 0, 4, 1, 0, 7, 64'h0246);
    run_case("t9_pause", 9, 0, 4, 3, -1, 0, 13, 1, 0, 9, 64'h0123444445678);
    run_case("t9_abort", 9, 0, -1, 0, 2, 0, 3, 0, 0, 2, 64'h012);
    run_case("t0", 0, 0, -1, 0, -1, 0, 0, 1, 0, 0, 64'h0);
    run_case("t15_s2", 15, 1, -1, 0, -1, 0, 8, 1, 0, 15, 64'h02468ACE);
    run_case("t5_spam", 5, 0, -1, 0, -1, 1, 5, 1, 0, 5, 64'h01234);
`ifdef COUNT_SEQ_TIMEOUT_EN
    run_case("hold_timeout", 3, 0, 1, 20, -1, 0, 10, 0, 1, 1, 64'h0111111111);
`else
    run_case("hold_long", 3, 0, 1, 20, -1, 0, 24, 1, 0, 3, 64'h1111111111111112);
`endif

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 300) begin
        #2 nReset = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
      end
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.target = 4'($urandom_range(0, 15));
      bus.step2  = 1'($urandom_range(0, 1));
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = int'($urandom_range(5, 12));
      if (burst > 0) begin bus.pause = 1'b1; burst--; end
      else bus.pause = ($urandom_range(0, 4) == 0);
      bus.abort  = ($urandom_range(0, 19) == 0);
      if (i % 100 == 99)
        $display("random cycle=%0d count=%0d busy=%0d done=%0d err=%0d", i, bus.count, bus.busy, bus.done, bus.err);
    end
    @(negedge clk);
    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
